// File: rtl/oled_refresh_scheduler.sv
// AHB-Lite slave that queues OLED block updates in a coalescing FIFO, keeps a shadow RAM
// of the last resource per block, and runs a periodic refresh sweep over all blocks.
module oled_refresh_scheduler #(
    parameter int unsigned Depth      = 8,
    parameter int unsigned BlockWidth = 5,
    parameter int unsigned ResWidth   = 5
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    input  logic [2:0]            HSIZE,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  upd_valid,
    output logic [BlockWidth-1:0] upd_block,
    output logic [ResWidth-1:0]   upd_resource,
    input  logic                  upd_ready
);
    localparam int unsigned PtrW      = $clog2(Depth);
    localparam int unsigned CntW      = PtrW + 1;
    localparam int unsigned NumBlocks = 1 << BlockWidth;

    localparam logic [5:0] AddrCtrl   = 6'h00;
    localparam logic [5:0] AddrPeriod = 6'h01;
    localparam logic [5:0] AddrStatus = 6'h02;
    localparam logic [5:0] AddrPush   = 6'h03;
    localparam logic [5:0] AddrFlush  = 6'h04;

    localparam logic [BlockWidth-1:0] LastBlock = '1;

    typedef enum logic [1:0] {
        StIdle,
        StQueue,
        StSweep
    } state_e;

    state_e                state_q, state_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [5:0]            addr_q, addr_d;
    logic                  enable_q, enable_d;
    logic                  refresh_en_q, refresh_en_d;
    logic [15:0]           period_q, period_d;
    logic [15:0]           timer_q, timer_d;
    logic                  overflow_q, overflow_d;
    logic                  pending_q, pending_d;
    logic [BlockWidth-1:0] fifo_blk_q [Depth];
    logic [BlockWidth-1:0] fifo_blk_d [Depth];
    logic [ResWidth-1:0]   fifo_res_q [Depth];
    logic [ResWidth-1:0]   fifo_res_d [Depth];
    logic [PtrW-1:0]       head_q, head_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ResWidth-1:0]   shadow_q [NumBlocks];
    logic [ResWidth-1:0]   shadow_d [NumBlocks];
    logic [BlockWidth-1:0] sweep_idx_q, sweep_idx_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [BlockWidth-1:0] upd_block_q, upd_block_d;
    logic [ResWidth-1:0]   upd_res_q, upd_res_d;

    logic                  sel_c, push_c, flush_c, hs_c, pop_c;
    logic                  pend_set_c, pend_clr_c, match_c;
    logic [PtrW-1:0]       head_pop_c, slot_c, match_idx_c, tail_c;
    logic [CntW-1:0]       cnt_pop_c;
    logic [BlockWidth-1:0] push_blk_c;
    logic [ResWidth-1:0]   push_res_c;
    logic                  sweep_active_c;
    logic                  unused_c;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            enable_q     <= 1'b0;
            refresh_en_q <= 1'b0;
            period_q     <= 16'hFFFF;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            pending_q    <= 1'b0;
            fifo_blk_q   <= '{default: '0};
            fifo_res_q   <= '{default: '0};
            head_q       <= '0;
            count_q      <= '0;
            shadow_q     <= '{default: '0};
            sweep_idx_q  <= '0;
            upd_valid_q  <= 1'b0;
            upd_block_q  <= '0;
            upd_res_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            enable_q     <= enable_d;
            refresh_en_q <= refresh_en_d;
            period_q     <= period_d;
            timer_q      <= timer_d;
            overflow_q   <= overflow_d;
            pending_q    <= pending_d;
            fifo_blk_q   <= fifo_blk_d;
            fifo_res_q   <= fifo_res_d;
            head_q       <= head_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            sweep_idx_q  <= sweep_idx_d;
            upd_valid_q  <= upd_valid_d;
            upd_block_q  <= upd_block_d;
            upd_res_q    <= upd_res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        enable_d     = enable_q;
        refresh_en_d = refresh_en_q;
        period_d     = period_q;
        timer_d      = timer_q;
        overflow_d   = overflow_q;
        fifo_blk_d   = fifo_blk_q;
        fifo_res_d   = fifo_res_q;
        shadow_d     = shadow_q;
        sweep_idx_d  = sweep_idx_q;
        upd_valid_d  = upd_valid_q;
        upd_block_d  = upd_block_q;
        upd_res_d    = upd_res_q;
        pop_c        = 1'b0;
        pend_set_c   = 1'b0;
        pend_clr_c   = 1'b0;
        match_c      = 1'b0;
        match_idx_c  = '0;
        slot_c       = '0;
        tail_c       = '0;

        sel_c = HSEL && HREADY && (HTRANS != 2'b00);
        if (sel_c) begin
            rd_d   = !HWRITE;
            wr_d   = HWRITE;
            addr_d = HADDR[7:2];
        end

        push_c     = wr_q && (addr_q == AddrPush);
        flush_c    = wr_q && (addr_q == AddrFlush);
        push_blk_c = HWDATA[BlockWidth-1:0];
        push_res_c = HWDATA[8 +: ResWidth];
        if (wr_q && (addr_q == AddrCtrl)) begin
            enable_d     = HWDATA[0];
            refresh_en_d = HWDATA[1];
        end
        if (wr_q && (addr_q == AddrPeriod)) begin
            period_d = HWDATA[15:0];
        end

        // >= rather than == so a PERIOD shrunk below the running count still wraps
        if (!refresh_en_q) begin
            timer_d = '0;
        end else if (period_q != 16'd0) begin
            if (timer_q >= period_q - 16'd1) begin
                timer_d    = '0;
                pend_set_c = 1'b1;
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end

        hs_c = upd_valid_q && upd_ready;
        case (state_q)
            StIdle: begin
                if (enable_q && (count_q != '0)) begin
                    state_d     = StQueue;
                    pop_c       = 1'b1;
                    upd_valid_d = 1'b1;
                    upd_block_d = fifo_blk_q[head_q];
                    upd_res_d   = fifo_res_q[head_q];
                end else if (enable_q && pending_q) begin
                    state_d     = StSweep;
                    upd_valid_d = 1'b1;
                    upd_block_d = sweep_idx_q;
                    upd_res_d   = shadow_q[sweep_idx_q];
                end
            end
            StQueue: begin
                if (hs_c) begin
                    state_d     = StIdle;
                    upd_valid_d = 1'b0;
                end
            end
            StSweep: begin
                if (hs_c) begin
                    state_d     = StIdle;
                    upd_valid_d = 1'b0;
                    sweep_idx_d = sweep_idx_q + BlockWidth'(1);
                    pend_clr_c  = (sweep_idx_q == LastBlock);
                end
            end
            default: state_d = StIdle;
        endcase
        pending_d = (pending_q && !pend_clr_c) || pend_set_c;

        // Pop first, then the push sees only the entries that remain queued
        head_pop_c = pop_c ? head_q + PtrW'(1) : head_q;
        cnt_pop_c  = pop_c ? count_q - CntW'(1) : count_q;
        head_d     = head_pop_c;
        count_d    = cnt_pop_c;
        if (push_c) begin
            shadow_d[push_blk_c] = push_res_c;
            for (int k = 0; k < int'(Depth); k++) begin
                slot_c = head_pop_c + PtrW'(k);
                if ((CntW'(k) < cnt_pop_c) && (fifo_blk_q[slot_c] == push_blk_c)) begin
                    match_c     = 1'b1;
                    match_idx_c = slot_c;
                end
            end
            if (match_c) begin
                fifo_res_d[match_idx_c] = push_res_c;
            end else if (cnt_pop_c < CntW'(Depth)) begin
                tail_c             = head_pop_c + PtrW'(cnt_pop_c);
                fifo_blk_d[tail_c] = push_blk_c;
                fifo_res_d[tail_c] = push_res_c;
                count_d            = cnt_pop_c + CntW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (flush_c) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    assign sweep_active_c = (pending_q && (sweep_idx_q != '0)) || (state_q == StSweep);

    // Read mux driven from the registered data-phase address
    always_comb begin
        HRDATA = '0;
        if (rd_q) begin
            case (addr_q)
                AddrCtrl:   HRDATA = {30'd0, refresh_en_q, enable_q};
                AddrPeriod: HRDATA = {16'd0, period_q};
                AddrStatus: HRDATA = {22'd0, overflow_q, sweep_active_c, 4'(count_q), 2'b00,
                                      (count_q == CntW'(Depth)), (count_q == '0)};
                default:    HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT    = 1'b1;
    assign upd_valid    = upd_valid_q;
    assign upd_block    = upd_block_q;
    assign upd_resource = upd_res_q;
    assign unused_c     = ^{HSIZE, HADDR[31:8], HADDR[1:0], HWDATA[31:16]};

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Directed bench for oled_refresh_scheduler: register access, queue/coalesce/overflow,
// refresh sweep with preemption and asynchronous reset.
module tb_oled_refresh_scheduler;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic        HREADY = 1'b1;
    logic        HWRITE = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        upd_valid;
    logic [4:0]  upd_block;
    logic [4:0]  upd_resource;
    logic        upd_ready = 1'b0;

    localparam logic [31:0] ACtrl   = 32'h00;
    localparam logic [31:0] APeriod = 32'h04;
    localparam logic [31:0] AStatus = 32'h08;
    localparam logic [31:0] APush   = 32'h0C;
    localparam logic [31:0] AFlush  = 32'h10;

    int checks = 0;
    int failures = 0;
    logic [4:0]  shadow_m [32];
    logic [31:0] rd;

    oled_refresh_scheduler dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HREADY      (HREADY),
        .HWRITE      (HWRITE),
        .HTRANS      (HTRANS),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HSIZE       (HSIZE),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .upd_valid   (upd_valid),
        .upd_block   (upd_block),
        .upd_resource(upd_resource),
        .upd_ready   (upd_ready)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge
    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    function automatic logic [31:0] push_word(input logic [4:0] b, input logic [4:0] r);
        return {16'd0, 3'd0, r, 3'd0, b};
    endfunction

    task automatic push(input logic [4:0] b, input logic [4:0] r);
        ahb_write(APush, push_word(b, r));
        shadow_m[b] = r;
    endtask

    // Two pipelined PUSH transfers: second address phase overlaps the first data phase
    task automatic push_pair(input logic [4:0] b1, input logic [4:0] r1,
                             input logic [4:0] b2, input logic [4:0] r2);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = APush;
        @(posedge HCLK); #1;
        HWDATA = push_word(b1, r1);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = push_word(b2, r2);
        @(posedge HCLK); #1;
        shadow_m[b1] = r1;
        shadow_m[b2] = r2;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!upd_valid && n < 60) begin
            @(posedge HCLK); #1;
            n++;
        end
    endtask

    task automatic take(input logic [4:0] b, input logic [4:0] r, input string tag);
        wait_valid();
        check({tag, "_valid"}, 32'(upd_valid), 32'd1);
        check({tag, "_block"}, 32'(upd_block), 32'(b));
        check({tag, "_res"}, 32'(upd_resource), 32'(r));
        upd_ready = 1'b1;
        @(posedge HCLK); #1;
        upd_ready = 1'b0;
        check({tag, "_drop"}, 32'(upd_valid), 32'd0);
    endtask

    initial begin
        foreach (shadow_m[i]) shadow_m[i] = '0;

        // Reset values
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_valid", 32'(upd_valid), 32'd0);
        check("rst_block", 32'(upd_block), 32'd0);
        check("rst_res", 32'(upd_resource), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(AStatus, rd); check("rst_status", rd, 32'h001);
        ahb_read(APeriod, rd); check("rst_period", rd, 32'h0000_FFFF);
        ahb_read(ACtrl, rd);   check("rst_ctrl", rd, 32'h0);
        ahb_read(32'h20, rd);  check("unmapped_rd", rd, 32'h0);

        // Single push, issue latency C+2
        ahb_write(ACtrl, 32'h1);
        upd_ready = 1'b1;
        push(5'd3, 5'd7);
        check("lat_c1_valid", 32'(upd_valid), 32'd0);
        @(posedge HCLK); #1;
        check("lat_c2_valid", 32'(upd_valid), 32'd1);
        check("lat_c2_block", 32'(upd_block), 32'd3);
        check("lat_c2_res", 32'(upd_resource), 32'd7);
        @(posedge HCLK); #1;
        upd_ready = 1'b0;
        check("lat_c3_valid", 32'(upd_valid), 32'd0);
        ahb_read(AStatus, rd); check("single_status", rd, 32'h001);

        // Push matching the entry popped that cycle is enqueued, not coalesced
        push_pair(5'd5, 5'd1, 5'd5, 5'd9);
        ahb_read(AStatus, rd); check("pair_status", rd, 32'h010);
        take(5'd5, 5'd1, "pair_first");
        take(5'd5, 5'd9, "pair_second");
        ahb_read(AStatus, rd); check("pair_empty", rd, 32'h001);

        // Fill, coalesce while full, overflow, flush
        for (int b = 10; b < 19; b++) push(5'(b), 5'(b));
        ahb_read(AStatus, rd); check("full_status", rd, 32'h082);
        push(5'd12, 5'd31);
        ahb_read(AStatus, rd); check("coalesce_full", rd, 32'h082);
        push(5'd19, 5'd3);
        ahb_read(AStatus, rd); check("overflow_status", rd, 32'h282);
        ahb_write(AFlush, 32'h0);
        ahb_read(AStatus, rd); check("flush_status", rd, 32'h001);
        take(5'd10, 5'd10, "flush_presented");
        repeat (5) @(posedge HCLK);
        #1;
        check("flush_no_issue", 32'(upd_valid), 32'd0);

        // Refresh sweep with preemption at block 10
        push(5'd2, 5'd6);
        take(5'd2, 5'd6, "shadow2");
        ahb_write(APeriod, 32'd4);
        ahb_write(ACtrl, 32'h3);
        take(5'd0, shadow_m[0], "sweep0");
        ahb_read(AStatus, rd); check("sweep_active", rd, 32'h101);
        ahb_write(ACtrl, 32'h1);
        for (int b = 1; b < 10; b++) take(5'(b), shadow_m[b], "sweep");
        wait_valid();
        check("sweep10_presented", 32'(upd_block), 32'd10);
        push(5'd7, 5'd21);
        take(5'd10, shadow_m[10], "sweep10");
        take(5'd7, 5'd21, "preempt");
        for (int b = 11; b < 32; b++) take(5'(b), shadow_m[b], "sweep");
        repeat (6) @(posedge HCLK);
        #1;
        check("sweep_done_valid", 32'(upd_valid), 32'd0);
        ahb_read(AStatus, rd); check("sweep_done_status", rd, 32'h001);

        // Asynchronous reset while a request is presented
        push(5'd4, 5'd4);
        wait_valid();
        check("prereset_valid", 32'(upd_valid), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("async_rst_valid", 32'(upd_valid), 32'd0);
        check("async_rst_block", 32'(upd_block), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(ACtrl, rd);   check("post_rst_ctrl", rd, 32'h0);
        ahb_read(APeriod, rd); check("post_rst_period", rd, 32'h0000_FFFF);
        ahb_read(AStatus, rd); check("post_rst_status", rd, 32'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oled_refresh_scheduler.md
# oled_refresh_scheduler

AHB-Lite slave that queues pixel-block update requests from software, coalesces duplicate requests and runs a periodic background refresh sweep. It issues one (block, resource) update at a time to the OLED drawing engine over a valid/ready handshake. It sits between the Cortex-M0 bus and the OLED block-drawing datapath, so software never polls the display serialiser.

## Interface
- `Depth`, default 8: FIFO entries (power of two).
- `BlockWidth`, default 5: block index width (32 blocks).
- `ResWidth`, default 5: resource index width.
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `HSEL, HREADY, HWRITE`  in  1 each  AHB-Lite control.
- `HTRANS`  in  2  AHB transfer type; 2'b00 means no transfer.
- `HADDR, HWDATA`  in  32 each  AHB address and write data.
- `HSIZE`  in  3  ignored; word access only.
- `HRDATA`  out  32  read data.
- `HREADYOUT`  out  1  constant 1.
- `upd_valid`  out  1  update request valid.
- `upd_block`  out  BlockWidth  block index.
- `upd_resource`  out  ResWidth  resource index.
- `upd_ready`  in  1  drawing engine accepts the request.

## Operation
- Address phase registered when HSEL && HREADY && HTRANS!=0. The write takes effect at the end of the data-phase cycle.
- Register map (word offsets):
  - 0x00 CTRL, R/W, reset 0: bit0 enable, bit1 refresh_en.
  - 0x04 PERIOD, R/W, reset 16'hFFFF: refresh period in HCLK cycles. 0 stops the timer.
  - 0x08 STATUS, RO: bit0 empty, bit1 full, bits[7:4] count, bit8 sweep_active, bit9 overflow (sticky).
  - 0x0C PUSH, WO: block = HWDATA[4:0], resource = HWDATA[12:8].
  - 0x10 FLUSH, WO: any write empties the FIFO and clears overflow.
  - Unmapped addresses read 0; writes to them are ignored.
- Shadow RAM holds 32×ResWidth entries, reset 0. Every push writes shadow[block] = resource.
- Push rules:
  - Coalescing: if a queued FIFO entry holds the same block, that entry's resource is replaced and count is unchanged.
  - Otherwise, if not full, the request is enqueued at the tail.
  - Otherwise, the request is dropped and overflow is set. The shadow RAM is still updated.
- Refresh timer:
  - Counts while refresh_en=1 and PERIOD!=0. At PERIOD-1 it wraps to 0 and sets refresh_pending; setting an already-set refresh_pending has no extra effect.
  - refresh_en=0 holds the counter at 0.
- Issue FSM states: Idle, Queue, Sweep.
  - Idle→Queue when enable && !empty. The FIFO head is popped into the upd_* output registers on this transition.
  - Idle→Sweep when enable && empty && refresh_pending. upd_block=sweep_idx, upd_resource=shadow[sweep_idx].
  - Queue→Idle on handshake.
  - Sweep→Idle on handshake. sweep_idx increments; on the handshake of index 31, sweep_idx wraps to 0 and refresh_pending clears.
  - Returning to Idle after every sweep entry lets queued requests preempt the sweep between entries.
  - sweep_active = refresh_pending && sweep_idx!=0, or state==Sweep.
- upd_valid is high only in Queue or Sweep. Payload is stable while valid; a valid request is never retracted.
- Clearing enable blocks new issues only; the presented request still completes.
- FLUSH does not affect the request currently presented, because it has already been popped.

## Timing
- Reset values: upd_valid=0, upd_block=0, upd_resource=0, HRDATA=0, HREADYOUT=1; FIFO empty; sweep_idx=0; refresh_pending=0.
- Reset asserted mid-handshake drops upd_valid immediately (asynchronous reset).
- Issue latency: PUSH data phase in cycle C → FIFO non-empty in C+1 → upd_valid=1 in C+2, provided the FSM is in Idle.
- A transfer completes at a rising edge with upd_valid && upd_ready. The next upd_valid comes no earlier than 2 cycles later because of the Idle turnaround.
- Pop and push in the same cycle while full: the pop is applied first and the push is accepted.
- Push that matches the entry being popped in the same cycle: the push is enqueued as a new entry; it does not modify the popped entry.
- Push and FLUSH cannot occur in the same cycle (single AHB port).
- HRDATA is combinational from the registered read address, valid in the data phase.

## Test plan
- Reset, then read STATUS → 0x001 (empty). Read PERIOD → 0xFFFF. upd_valid=0.
- enable=1; PUSH block 3/res 7 with upd_ready=1 → upd_valid high 2 cycles after the data phase with 3/7, then low. STATUS returns to empty.
- upd_ready=0; PUSH 5/1 then 5/9 → the first is presented as 5/1. The second is enqueued (the first is already popped), giving count 1. Release ready → 5/1 issues, then 5/9.
- upd_ready=0; 9 distinct pushes (1 is presented, 8 fill the FIFO), then a 10th → full=1, overflow=1, shadow updated. FLUSH → empty, overflow=0, the presented request still completes.
- PERIOD=4, refresh_en=1, enable=1, shadow[2]=6 → a sweep issues blocks 0..31, with block 2 carrying resource 6. refresh_pending clears after block 31.
- A PUSH during the sweep at block 10 → the pushed request issues before block 11. The sweep then resumes at 11.
